// File: rtl/alu_pipe.sv
// alu_pipe: two-stage integer ALU (S1 operand register, S2 result register) that returns results to the ROB.
// Define ALU_MUL_EN to add MUL/MULH/MULHSU/MULHU, which hold S2 for MUL_LAT cycles before presenting.
`ifndef OpcodeLength
`define OpcodeLength 5
`endif

module alu_pipe #(
  parameter int XLEN    = 32,
  parameter int TAG_W   = 4,
  parameter int MUL_LAT = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [`OpcodeLength:0] in_op,
  input  logic [XLEN-1:0]        in_v1,
  input  logic [XLEN-1:0]        in_v2,
  input  logic [XLEN-1:0]        in_imm,
  input  logic [XLEN-1:0]        in_pc,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_data,
  output logic [XLEN-1:0]        out_jpc,
  output logic                   out_taken,
  output logic [TAG_W-1:0]       out_tag,
  output logic                   out_illegal
);

  typedef enum logic [`OpcodeLength:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU
  } op_e;

  localparam int SH_W  = (XLEN == 64) ? 6 : 5;
  localparam int CNT_W = $clog2(MUL_LAT + 1);

  logic                   s1_valid;
  logic [`OpcodeLength:0] s1_op;
  logic [XLEN-1:0]        s1_v1, s1_v2, s1_imm, s1_pc;
  logic [TAG_W-1:0]       s1_tag;
  logic                   s2_valid;
  logic [CNT_W-1:0]       mul_cnt;

  logic                   s2_free, s1_adv, accept;
  logic [SH_W-1:0]        sh_r, sh_i;
  logic [XLEN-1:0]        pc4, imm_hi, br_tgt;
  logic [XLEN-1:0]        r_data, r_jpc;
  logic                   r_taken, r_illegal, r_mul, is_br;

  // A multiply sitting in S2 with a nonzero counter is not yet visible and blocks S1.
  assign out_valid = s2_valid && (mul_cnt == '0);
  assign s2_free   = !s2_valid || (out_valid && out_ready);
  assign s1_adv    = s1_valid && s2_free && !flush;
  assign in_ready  = !rst && !flush && (!s1_valid || s1_adv);
  assign accept    = in_valid && in_ready;

  assign sh_r   = s1_v2[SH_W-1:0];
  assign sh_i   = s1_imm[SH_W-1:0];
  assign pc4    = s1_pc + XLEN'(4);
  assign imm_hi = s1_imm << 12;
  assign br_tgt = s1_pc + s1_imm;

`ifdef ALU_MUL_EN
  logic [2*XLEN-1:0] mul_a, mul_b, prod;

  // One multiplier; signedness is chosen by extending the operands to 2*XLEN bits.
  assign mul_a = {{XLEN{((s1_op == OP_MULH) || (s1_op == OP_MULHSU)) && s1_v1[XLEN-1]}}, s1_v1};
  assign mul_b = {{XLEN{(s1_op == OP_MULH) && s1_v2[XLEN-1]}}, s1_v2};
  assign prod  = mul_a * mul_b;
`endif

  always_comb begin
    r_data    = '0;
    r_jpc     = pc4;
    r_taken   = 1'b0;
    r_illegal = 1'b0;
    r_mul     = 1'b0;
    is_br     = 1'b0;
    case (s1_op)
      OP_ADD:   r_data = s1_v1 + s1_v2;
      OP_SUB:   r_data = s1_v1 - s1_v2;
      OP_SLL:   r_data = s1_v1 << sh_r;
      OP_SLT:   r_data = {{(XLEN-1){1'b0}}, $signed(s1_v1) < $signed(s1_v2)};
      OP_SLTU:  r_data = {{(XLEN-1){1'b0}}, s1_v1 < s1_v2};
      OP_XOR:   r_data = s1_v1 ^ s1_v2;
      OP_SRL:   r_data = s1_v1 >> sh_r;
      OP_SRA:   r_data = $signed(s1_v1) >>> sh_r;
      OP_OR:    r_data = s1_v1 | s1_v2;
      OP_AND:   r_data = s1_v1 & s1_v2;
      OP_ADDI:  r_data = s1_v1 + s1_imm;
      OP_SLTI:  r_data = {{(XLEN-1){1'b0}}, $signed(s1_v1) < $signed(s1_imm)};
      OP_SLTIU: r_data = {{(XLEN-1){1'b0}}, s1_v1 < s1_imm};
      OP_XORI:  r_data = s1_v1 ^ s1_imm;
      OP_ORI:   r_data = s1_v1 | s1_imm;
      OP_ANDI:  r_data = s1_v1 & s1_imm;
      OP_SLLI:  r_data = s1_v1 << sh_i;
      OP_SRLI:  r_data = s1_v1 >> sh_i;
      OP_SRAI:  r_data = $signed(s1_v1) >>> sh_i;
      OP_LUI:   r_data = imm_hi;
      OP_AUIPC: r_data = s1_pc + imm_hi;
      OP_JAL: begin
        r_data  = pc4;
        r_jpc   = br_tgt;
        r_taken = 1'b1;
      end
      OP_JALR: begin
        r_data  = pc4;
        r_jpc   = (s1_v1 + s1_imm) & ~XLEN'(1);
        r_taken = 1'b1;
      end
      OP_BEQ:  begin is_br = 1'b1; r_taken = (s1_v1 == s1_v2); end
      OP_BNE:  begin is_br = 1'b1; r_taken = (s1_v1 != s1_v2); end
      OP_BLT:  begin is_br = 1'b1; r_taken = ($signed(s1_v1) < $signed(s1_v2)); end
      OP_BGE:  begin is_br = 1'b1; r_taken = ($signed(s1_v1) >= $signed(s1_v2)); end
      OP_BLTU: begin is_br = 1'b1; r_taken = (s1_v1 < s1_v2); end
      OP_BGEU: begin is_br = 1'b1; r_taken = (s1_v1 >= s1_v2); end
`ifdef ALU_MUL_EN
      OP_MUL: begin
        r_mul  = 1'b1;
        r_data = prod[XLEN-1:0];
      end
      OP_MULH, OP_MULHSU, OP_MULHU: begin
        r_mul  = 1'b1;
        r_data = prod[2*XLEN-1:XLEN];
      end
`endif
      default: r_illegal = 1'b1;
    endcase
    if (is_br && r_taken)
      r_jpc = br_tgt;
  end

  // Operand register: holds an op until the result register can take it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_v1    <= '0;
      s1_v2    <= '0;
      s1_imm   <= '0;
      s1_pc    <= '0;
      s1_tag   <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_op    <= in_op;
      s1_v1    <= in_v1;
      s1_v2    <= in_v2;
      s1_imm   <= in_imm;
      s1_pc    <= in_pc;
      s1_tag   <= in_tag;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Result register: outputs only change on load, so a stalled result stays stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid    <= 1'b0;
      mul_cnt     <= '0;
      out_data    <= '0;
      out_jpc     <= '0;
      out_taken   <= 1'b0;
      out_tag     <= '0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      s2_valid <= 1'b0;
      mul_cnt  <= '0;
    end else if (s1_adv) begin
      s2_valid    <= 1'b1;
      mul_cnt     <= r_mul ? CNT_W'(MUL_LAT) : '0;
      out_data    <= r_data;
      out_jpc     <= r_jpc;
      out_taken   <= r_taken;
      out_tag     <= s1_tag;
      out_illegal <= r_illegal;
    end else if (out_valid && out_ready) begin
      s2_valid <= 1'b0;
    end else if (mul_cnt != '0) begin
      mul_cnt <= mul_cnt - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed bench for alu_pipe with an in-bench result model and per-cycle output checker.
// Follows ALU_MUL_EN the same way as the design for multiply expectations.
`ifndef OpcodeLength
`define OpcodeLength 5
`endif

module tb_alu_pipe;

  localparam int OP_ADD = 0,  OP_SUB = 1,  OP_SLL = 2,  OP_SLT = 3,  OP_SLTU = 4;
  localparam int OP_XOR = 5,  OP_SRL = 6,  OP_SRA = 7,  OP_OR = 8,   OP_AND = 9;
  localparam int OP_ADDI = 10, OP_SLTI = 11, OP_SLTIU = 12, OP_XORI = 13, OP_ORI = 14;
  localparam int OP_ANDI = 15, OP_SLLI = 16, OP_SRLI = 17, OP_SRAI = 18;
  localparam int OP_LUI = 19, OP_AUIPC = 20, OP_JAL = 21, OP_JALR = 22;
  localparam int OP_BEQ = 23, OP_BNE = 24, OP_BLT = 25, OP_BGE = 26, OP_BLTU = 27, OP_BGEU = 28;
  localparam int OP_MUL = 29, OP_MULH = 30, OP_MULHSU = 31, OP_MULHU = 32;

`ifdef ALU_MUL_EN
  localparam int   MUL_CYC = 5;
  localparam logic MUL_ILL = 1'b0;
`else
  localparam int   MUL_CYC = 2;
  localparam logic MUL_ILL = 1'b1;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] jpc;
    logic        taken;
    logic [3:0]  tag;
    logic        illegal;
  } res_t;

  logic                   clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [`OpcodeLength:0] in_op;
  logic [31:0]            in_v1, in_v2, in_imm, in_pc, out_data, out_jpc;
  logic [3:0]             in_tag, out_tag;
  logic                   out_taken, out_illegal;

  int   n_compared = 0;
  int   n_mismatched = 0;
  int   delivered = 0;
  res_t exp_q[$];
  logic [31:0] out_log[$];
  logic stall_prev = 1'b0;
  logic prev_flush = 1'b0;
  res_t held;
  logic cap_valid, cap_taken, cap_illegal;
  logic [31:0] cap_data, cap_jpc;
  logic [3:0]  cap_tag;
  logic [3:0]  tag_ctr = 4'd0;

  alu_pipe #(.XLEN(32), .TAG_W(4), .MUL_LAT(3)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_v1(in_v1), .in_v2(in_v2), .in_imm(in_imm), .in_pc(in_pc), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_jpc(out_jpc), .out_taken(out_taken),
    .out_tag(out_tag), .out_illegal(out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic res_t model(input int op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] tag);
    res_t r;
    logic take;
    longint p;
    logic [63:0] u;
    r.data = 32'd0; r.jpc = pc + 32'd4; r.taken = 1'b0; r.tag = tag; r.illegal = 1'b0;
    take = 1'b0; p = 0; u = 64'd0;
    case (op)
      OP_ADD:   r.data = a + b;
      OP_SUB:   r.data = a - b;
      OP_SLL:   r.data = a << b[4:0];
      OP_SLT:   r.data = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTU:  r.data = (a < b) ? 32'd1 : 32'd0;
      OP_XOR:   r.data = a ^ b;
      OP_SRL:   r.data = a >> b[4:0];
      OP_SRA:   r.data = $signed(a) >>> b[4:0];
      OP_OR:    r.data = a | b;
      OP_AND:   r.data = a & b;
      OP_ADDI:  r.data = a + imm;
      OP_SLTI:  r.data = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
      OP_SLTIU: r.data = (a < imm) ? 32'd1 : 32'd0;
      OP_XORI:  r.data = a ^ imm;
      OP_ORI:   r.data = a | imm;
      OP_ANDI:  r.data = a & imm;
      OP_SLLI:  r.data = a << imm[4:0];
      OP_SRLI:  r.data = a >> imm[4:0];
      OP_SRAI:  r.data = $signed(a) >>> imm[4:0];
      OP_LUI:   r.data = imm * 32'd4096;
      OP_AUIPC: r.data = pc + imm * 32'd4096;
      OP_JAL:   begin r.data = pc + 32'd4; r.jpc = pc + imm; r.taken = 1'b1; end
      OP_JALR:  begin r.data = pc + 32'd4; r.jpc = (a + imm) & 32'hFFFF_FFFE; r.taken = 1'b1; end
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
        case (op)
          OP_BEQ:  take = (a == b);
          OP_BNE:  take = (a != b);
          OP_BLT:  take = ($signed(a) < $signed(b));
          OP_BGE:  take = !($signed(a) < $signed(b));
          OP_BLTU: take = (a < b);
          default: take = !(a < b);
        endcase
        r.taken = take;
        r.jpc   = take ? pc + imm : pc + 32'd4;
      end
`ifdef ALU_MUL_EN
      OP_MUL:    begin p = longint'($signed(a)) * longint'($signed(b)); r.data = p[31:0]; end
      OP_MULH:   begin p = longint'($signed(a)) * longint'($signed(b)); r.data = p[63:32]; end
      OP_MULHSU: begin p = longint'($signed(a)) * longint'({32'd0, b}); r.data = p[63:32]; end
      OP_MULHU:  begin u = {32'd0, a} * {32'd0, b}; r.data = u[63:32]; end
`endif
      default: r.illegal = 1'b1;
    endcase
    return r;
  endfunction

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  // Scoreboard: predict at acceptance, compare at each handshake, watch held and flushed outputs.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      stall_prev = 1'b0;
      prev_flush = 1'b0;
    end else begin
      if (prev_flush)
        check_output("valid_after_flush", out_valid, 1'b0);
      else if (stall_prev) begin
        check_output("hold_valid", out_valid, 1'b1);
        check_output("hold_data", out_data, held.data);
        check_output("hold_jpc", out_jpc, held.jpc);
        check_output("hold_misc", {out_taken, out_tag, out_illegal}, {held.taken, held.tag, held.illegal});
      end
      if (out_valid && out_ready) begin
        check_output("result_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          res_t e;
          e = exp_q.pop_front();
          check_output("res_data", out_data, e.data);
          check_output("res_jpc", out_jpc, e.jpc);
          check_output("res_taken", out_taken, e.taken);
          check_output("res_tag", out_tag, e.tag);
          check_output("res_illegal", out_illegal, e.illegal);
        end
        delivered++;
        out_log.push_back(out_data);
      end
      stall_prev = out_valid && !out_ready;
      held = '{data: out_data, jpc: out_jpc, taken: out_taken, tag: out_tag, illegal: out_illegal};
      if (in_valid && in_ready)
        exp_q.push_back(model(int'(in_op), in_v1, in_v2, in_imm, in_pc, in_tag));
      if (flush) begin
        check_output("ready_in_flush", in_ready, 1'b0);
        exp_q.delete();
      end
      prev_flush = flush;
    end
  end

  task automatic drive_inputs(input int op, input logic [31:0] v1, input logic [31:0] v2,
                              input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] tag);
    in_op  = op[`OpcodeLength:0];
    in_v1  = v1;
    in_v2  = v2;
    in_imm = imm;
    in_pc  = pc;
    in_tag = tag;
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
  task automatic apply_stimulus(input int op, input logic [31:0] v1, input logic [31:0] v2,
                                input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] tag);
    int budget;
    budget = 0;
    drive_inputs(op, v1, v2, imm, pc, tag);
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready)
      check_output("accept_timeout", in_ready, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_and_capture(input int op, input logic [31:0] v1, input logic [31:0] v2,
                                   input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] tag);
    @(posedge clk); #1;
    drive_inputs(op, v1, v2, imm, pc, tag);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    cap_valid = out_valid; cap_data = out_data; cap_jpc = out_jpc;
    cap_taken = out_taken; cap_tag = out_tag; cap_illegal = out_illegal;
  endtask

  task automatic wait_drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    check_output("drain_empty", exp_q.size(), 0);
  endtask

  task automatic send_tagged(input int op, input logic [31:0] v1, input logic [31:0] v2,
                             input logic [31:0] imm, input logic [31:0] pc);
    tag_ctr = tag_ctr + 4'd1;
    apply_stimulus(op, v1, v2, imm, pc, tag_ctr);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int snap;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive_inputs(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #2;
    check_output("rst_out_valid", out_valid, 1'b0);
    check_output("rst_in_ready", in_ready, 1'b0);
    check_output("rst_out_data", out_data, 32'd0);
    check_output("rst_out_misc", {out_jpc, out_tag, out_taken, out_illegal}, 38'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_output("ready_after_reset", in_ready, 1'b1);

    apply_and_capture(OP_ADD, 32'd5, -32'sd3, 32'd0, 32'h200, 4'd2);
    check_output("add_valid", cap_valid, 1'b1);
    check_output("add_data", cap_data, 32'd2);
    check_output("add_tag", cap_tag, 4'd2);
    check_output("add_jpc", cap_jpc, 32'h204);

    apply_and_capture(OP_BLTU, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFF8, 32'h100, 4'd3);
    check_output("bltu_taken", cap_taken, 1'b1);
    check_output("bltu_jpc", cap_jpc, 32'hF8);
    apply_and_capture(OP_BLT, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFF8, 32'h100, 4'd4);
    check_output("blt_taken", cap_taken, 1'b0);
    check_output("blt_jpc", cap_jpc, 32'h104);
    check_output("blt_data", cap_data, 32'd0);

    apply_and_capture(OP_JALR, 32'h1001, 32'd0, 32'd2, 32'h40, 4'd5);
    check_output("jalr_data", cap_data, 32'h44);
    check_output("jalr_jpc", cap_jpc, 32'h1002);
    check_output("jalr_taken", cap_taken, 1'b1);
    apply_and_capture(OP_SRA, 32'h8000_0000, 32'd4, 32'd0, 32'h0, 4'd6);
    check_output("sra_data", cap_data, 32'hF800_0000);
    apply_and_capture(OP_SLTIU, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'h0, 4'd7);
    check_output("sltiu_data", cap_data, 32'd1);
    apply_and_capture(OP_LUI, 32'd0, 32'd0, 32'h12345, 32'h0, 4'd8);
    check_output("lui_data", cap_data, 32'h1234_5000);
    apply_and_capture(63, 32'd9, 32'd9, 32'd9, 32'h80, 4'd9);
    check_output("illegal_flag", cap_illegal, 1'b1);
    check_output("illegal_data", cap_data, 32'd0);
    check_output("illegal_jpc", cap_jpc, 32'h84);

    // Back-to-back ADDIs with the ROB stalling cycles 2-4.
    wait_drain();
    out_log.delete();
    @(posedge clk); #1;
    fork
      begin
        for (int i = 0; i < 4; i++)
          apply_stimulus(OP_ADDI, i * 100, 32'd0, 32'd1, 32'h400 + i * 4, 4'(i + 1));
        in_valid = 1'b0;
      end
      begin
        @(posedge clk); @(posedge clk); #1;
        out_ready = 1'b0;
        @(posedge clk); #2;
        check_output("ready_drops_on_stall", in_ready, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();
    check_output("bp_count", out_log.size(), 4);
    if (out_log.size() == 4) begin
      check_output("bp_order0", out_log[0], 32'd1);
      check_output("bp_order1", out_log[1], 32'd101);
      check_output("bp_order2", out_log[2], 32'd201);
      check_output("bp_order3", out_log[3], 32'd301);
    end

    // Flush with ops in both stages, and a new op offered during the flush.
    out_ready = 1'b0;
    @(posedge clk); #1;
    apply_stimulus(OP_ADDI, 32'd7, 32'd0, 32'd1, 32'h500, 4'd10);
    apply_stimulus(OP_ADDI, 32'd8, 32'd0, 32'd1, 32'h504, 4'd11);
    drive_inputs(OP_ADD, 32'd1, 32'd1, 32'd0, 32'h508, 4'd12);
    in_valid = 1'b1;
    flush = 1'b1;
    #1;
    check_output("flush_blocks_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    check_output("flush_clears_valid", out_valid, 1'b0);
    snap = delivered;
    repeat (6) @(posedge clk);
    #2;
    check_output("flush_nothing_emerges", delivered, snap);

    // Multiply latency and result.
    @(posedge clk); #1;
    drive_inputs(OP_MUL, 32'h10000, 32'h10000, 32'd0, 32'h600, 4'd5);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      #1;
      check_output($sformatf("mul_valid_c%0d", c), out_valid, c == MUL_CYC);
      if (c == MUL_CYC) begin
        check_output("mul_data", out_data, 32'd0);
        check_output("mul_illegal", out_illegal, MUL_ILL);
        check_output("mul_tag", out_tag, 4'd5);
      end
      @(posedge clk); #1;
    end

    // Mixed stream through the model with a toggling ROB ready.
    wait_drain();
    @(posedge clk); #1;
    fork
      begin
        send_tagged(OP_SUB, 32'd3, 32'd5, 32'd0, 32'h10);
        send_tagged(OP_SLL, 32'd1, 32'd33, 32'd0, 32'h14);
        send_tagged(OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h18);
        send_tagged(OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h1C);
        send_tagged(OP_XOR, 32'hF0F0, 32'h0FF0, 32'd0, 32'h20);
        send_tagged(OP_SRL, 32'h8000_0000, 32'd31, 32'd0, 32'h24);
        send_tagged(OP_SRA, 32'h8000_0000, 32'd36, 32'd0, 32'h28);
        send_tagged(OP_OR, 32'hA0, 32'h05, 32'd0, 32'h2C);
        send_tagged(OP_AND, 32'hFF, 32'h3C, 32'd0, 32'h30);
        send_tagged(OP_SLTI, 32'hFFFF_FFFE, 32'd0, 32'hFFFF_FFFF, 32'h34);
        send_tagged(OP_XORI, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'h38);
        send_tagged(OP_ORI, 32'h100, 32'd0, 32'h0F, 32'h3C);
        send_tagged(OP_ANDI, 32'h1234, 32'd0, 32'hFF, 32'h40);
        send_tagged(OP_SLLI, 32'd3, 32'd0, 32'h21, 32'h44);
        send_tagged(OP_SRLI, 32'hF000_0000, 32'd0, 32'd4, 32'h48);
        send_tagged(OP_SRAI, 32'hF000_0000, 32'd0, 32'd4, 32'h4C);
        send_tagged(OP_AUIPC, 32'd0, 32'd0, 32'd1, 32'h1000);
        send_tagged(OP_JAL, 32'd0, 32'd0, 32'hFFFF_FFF0, 32'h300);
        send_tagged(OP_BEQ, 32'd9, 32'd9, 32'h20, 32'h700);
        send_tagged(OP_BNE, 32'd9, 32'd9, 32'h20, 32'h704);
        send_tagged(OP_BGE, 32'h8000_0000, 32'd1, 32'h20, 32'h708);
        send_tagged(OP_BGEU, 32'h8000_0000, 32'd1, 32'h20, 32'h70C);
        send_tagged(OP_MUL, 32'd7, 32'd6, 32'd0, 32'h800);
        send_tagged(OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'h804);
        send_tagged(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'h808);
        send_tagged(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'h80C);
        send_tagged(45, 32'd1, 32'd2, 32'd3, 32'h810);
        in_valid = 1'b0;
      end
      begin
        for (int k = 0; k < 40; k++) begin
          out_ready = (k % 3) != 2;
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // Reset pulsed while a multiply occupies the pipe.
    out_ready = 1'b0;
    @(posedge clk); #1;
    drive_inputs(OP_MUL, 32'd3, 32'd5, 32'd0, 32'h900, 4'd7);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    stall_prev = 1'b0;
    #1;
    check_output("rstmul_out_valid", out_valid, 1'b0);
    check_output("rstmul_in_ready", in_ready, 1'b0);
    check_output("rstmul_zero", {out_data, out_tag, out_illegal}, 37'd0);
    #1;
    rst = 1'b0;
    #1;
    check_output("rstmul_ready_release", in_ready, 1'b1);
    out_ready = 1'b1;
    snap = delivered;
    repeat (8) @(posedge clk);
    #2;
    check_output("rstmul_discarded", delivered, snap);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
